// File: rtl/q_frag_pkg.sv
// Shared constants and helpers for the q_frag elastic register pipeline.
// Imported by q_frag_stage and q_frag_pipe.
package q_frag_pkg;

  localparam logic QDS_SEL_QDI = 1'b1;
  localparam logic QDS_SEL_CZI = 1'b0;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/q_frag_stage.sv
// One pipeline stage of q_frag_pipe: a data register plus its valid bit.
// Set wins over load, load wins over clear.
module q_frag_stage
  import q_frag_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             QCK,
  input  logic             QRTN,
  input  logic             QST,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] SET_VAL,
  output logic [WIDTH-1:0] q,
  output logic             v
);

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      q <= '0;
      v <= 1'b0;
    end else if (QST) begin
      q <= SET_VAL;
      v <= 1'b0;
    end else if (load) begin
      q <= d;
      v <= 1'b1;
    end else if (clear) begin
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/q_frag_pipe.sv
// WIDTH x DEPTH elastic register pipeline with valid/ready handshake.
// Define Q_FRAG_PIPE_OCC_EN to add the QOCC occupancy counter port.
module q_frag_pipe
  import q_frag_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input  logic             QCK,
  input  logic             QRTN,
  input  logic             QST,
  input  logic             QEN,
  input  logic             QDS,
  input  logic [WIDTH-1:0] QDI,
  input  logic [WIDTH-1:0] CZI,
  input  logic             QIV,
  output logic             QIR,
  output logic [WIDTH-1:0] QZ,
  output logic             QZV,
  input  logic             QZR
`ifdef Q_FRAG_PIPE_OCC_EN
  ,
  output logic [occ_w(DEPTH)-1:0] QOCC
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] clear;
  logic [WIDTH-1:0] data [DEPTH];
  logic [WIDTH-1:0] din  [DEPTH];
  logic [WIDTH-1:0] d;
  logic             accept;
  logic             carry;

  // Walk from the output side so each stage sees its successor's advance.
  always_comb begin
    adv   = '0;
    carry = QEN & v[DEPTH-1] & QZR;
    adv[DEPTH-1] = carry;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      carry  = QEN & v[i] & (~v[i+1] | carry);
      adv[i] = carry;
    end
  end

  assign QIR    = QEN & (~v[0] | adv[0]);
  assign accept = QIV & QIR;
  assign d      = (QDS == QDS_SEL_QDI) ? QDI : CZI;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign din[g]  = d;
      assign load[g] = accept;
    end else begin : g_body
      assign din[g]  = data[g-1];
      assign load[g] = adv[g-1];
    end
    assign clear[g] = adv[g];

    q_frag_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .QCK    (QCK),
      .QRTN   (QRTN),
      .QST    (QST),
      .load   (load[g]),
      .clear  (clear[g]),
      .d      (din[g]),
      .SET_VAL(SET_VAL),
      .q      (data[g]),
      .v      (v[g])
    );
  end

  assign QZ  = data[DEPTH-1];
  assign QZV = v[DEPTH-1];

`ifdef Q_FRAG_PIPE_OCC_EN
  localparam int OW = occ_w(DEPTH);

  logic [OW-1:0] occ;
  logic          emit;

  assign emit = adv[DEPTH-1];

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      occ <= '0;
    end else if (QST) begin
      occ <= '0;
    end else if (accept & ~emit) begin
      occ <= occ + OW'(1);
    end else if (emit & ~accept) begin
      occ <= occ - OW'(1);
    end
  end

  assign QOCC = occ;
`endif

endmodule

// File: tb/tb_q_frag_pipe.sv
// Scoreboard bench for q_frag_pipe (WIDTH=8, DEPTH=2).
// Occupancy checks are active when Q_FRAG_PIPE_OCC_EN is defined.
module tb_q_frag_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             QCK  = 1'b0;
  logic             QRTN = 1'b0;
  logic             QST  = 1'b0;
  logic             QEN  = 1'b1;
  logic             QDS  = 1'b1;
  logic [WIDTH-1:0] QDI  = '0;
  logic [WIDTH-1:0] CZI  = '0;
  logic             QIV  = 1'b0;
  logic             QZR  = 1'b1;
  logic             QIR;
  logic [WIDTH-1:0] QZ;
  logic             QZV;
`ifdef Q_FRAG_PIPE_OCC_EN
  logic [1:0]       QOCC;
`endif

  int               checks   = 0;
  int               failures = 0;
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] exp_w = '0;

  q_frag_pipe #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .SET_VAL(8'hFF)
  ) dut (
    .QCK (QCK),
    .QRTN(QRTN),
    .QST (QST),
    .QEN (QEN),
    .QDS (QDS),
    .QDI (QDI),
    .CZI (CZI),
    .QIV (QIV),
    .QIR (QIR),
    .QZ  (QZ),
    .QZV (QZV),
    .QZR (QZR)
`ifdef Q_FRAG_PIPE_OCC_EN
    ,
    .QOCC(QOCC)
`endif
  );

  always #5 QCK = ~QCK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  // Record accepts (or a flush) at the negedge, then step past the edge.
  task automatic cyc();
    @(negedge QCK);
    if (!QRTN || QST) exp_q.delete();
    else if (QIV && QIR) exp_q.push_back(exp_w);
    @(posedge QCK);
    #1;
`ifdef Q_FRAG_PIPE_OCC_EN
    chk("occ", QOCC, exp_q.size());
    chk("occ_max", 32'(QOCC <= 2'(DEPTH)), 1);
`endif
  endtask

  initial begin
    forever begin
      @(negedge QCK);
      if (QRTN && QZV && QZR && QEN && !QST) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out act=%0h req=none", QZ);
        end else begin
          chk("data", QZ, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    // reset held with traffic offered
    QIV = 1'b1; QDI = 8'h3C; CZI = 8'hC3;
    repeat (2) cyc();
    chk("rst_qz", QZ, 8'h00);
    chk("rst_qzv", QZV, 0);
    QIV = 1'b0; QRTN = 1'b1;
    #1;
    chk("rst_qir", QIR, 1);

    // streaming
    QDS = 1'b1; QIV = 1'b1;
    QDI = 8'h11; exp_w = 8'h11; cyc();
    chk("lat_qzv0", QZV, 0);
    QDI = 8'h22; exp_w = 8'h22; cyc();
    chk("lat_qzv1", QZV, 1);
    chk("str_11", QZ, 8'h11);
    QDI = 8'h33; exp_w = 8'h33; cyc();
    chk("str_22", QZ, 8'h22);
    QIV = 1'b0; cyc();
    chk("str_33", QZ, 8'h33);
    cyc();
    chk("str_empty", QZV, 0);

    // backpressure
    QZR = 1'b0; QIV = 1'b1;
    QDI = 8'hA1; exp_w = 8'hA1; cyc();
    QDI = 8'hA2; exp_w = 8'hA2; cyc();
    QDI = 8'hA3; exp_w = 8'hA3;
    chk("bp_qir", QIR, 0);
    chk("bp_qz", QZ, 8'hA1);
    chk("bp_qzv", QZV, 1);
    cyc();
    chk("bp_hold_qir", QIR, 0);
    chk("bp_hold_qz", QZ, 8'hA1);
    QZR = 1'b1;
    #1;
    chk("bp_release_qir", QIR, 1);
    cyc();
    QIV = 1'b0;
    repeat (3) cyc();
    chk("bp_drained", QZV, 0);

    // input mux
    QIV = 1'b1;
    QDS = 1'b0; CZI = 8'hA5; QDI = 8'h5A; exp_w = 8'hA5; cyc();
    QDS = 1'b1; CZI = 8'hC3; QDI = 8'h3C; exp_w = 8'h3C; cyc();
    chk("mux_czi", QZ, 8'hA5);
    QDS = 1'b0; exp_w = 8'hC3; cyc();
    chk("mux_qdi", QZ, 8'h3C);
    QIV = 1'b0;
    repeat (3) cyc();

    // clock enable freeze
    QDS = 1'b1; QIV = 1'b1;
    QDI = 8'hB1; exp_w = 8'hB1; cyc();
    QDI = 8'hB2; exp_w = 8'hB2; cyc();
    QEN = 1'b0; QDI = 8'hB3; exp_w = 8'hB3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("qen_qir", QIR, 0);
      cyc();
      chk("qen_qz", QZ, 8'hB1);
      chk("qen_qzv", QZV, 1);
    end
    QEN = 1'b1;
    cyc();
    QIV = 1'b0;
    repeat (3) cyc();

    // sync set with a word offered at the same time
    QZR = 1'b0; QIV = 1'b1;
    QDI = 8'hC1; exp_w = 8'hC1; cyc();
    QST = 1'b1; QDI = 8'hC7; exp_w = 8'hC7;
    #1;
    chk("qst_qir", QIR, 1);
    cyc();
    QST = 1'b0; QIV = 1'b0;
    chk("qst_qz", QZ, 8'hFF);
    chk("qst_qzv", QZV, 0);
    QZR = 1'b1;
    repeat (3) cyc();
    chk("qst_nothing_out", QZV, 0);

    // random traffic
    for (int i = 0; i < 1000; i++) begin
      QIV = 1'($urandom_range(0, 1));
      QZR = 1'($urandom_range(0, 1));
      QEN = ($urandom_range(0, 7) != 0);
      QDS = 1'b1;
      QDI = 8'($urandom);
      exp_w = QDI;
      cyc();
    end
    QEN = 1'b1; QZR = 1'b1; QIV = 1'b0;
    repeat (20) cyc();
    chk("drain_left", exp_q.size(), 0);

    // asynchronous reset mid-transfer
    QZR = 1'b0; QIV = 1'b1;
    QDI = 8'hD1; exp_w = 8'hD1; cyc();
    QDI = 8'hD2; exp_w = 8'hD2; cyc();
    QIV = 1'b0;
    chk("arst_pre_qzv", QZV, 1);
    #2 QRTN = 1'b0;
    #1;
    chk("arst_qzv", QZV, 0);
    chk("arst_qz", QZ, 8'h00);
    cyc();
    QRTN = 1'b1; QZR = 1'b1;
    repeat (3) cyc();
    chk("arst_after_qzv", QZV, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q_frag_pipe.md
Name: q_frag_pipe

Overview:
- Parametrised successor of the single-bit logic-cell flip-flop. It provides a WIDTH-bit, DEPTH-stage elastic register pipeline.
- Keeps the cell's features: QDS input mux between QDI and CZI, clock enable, set-to-value.
- Adds a valid/ready handshake and per-stage occupancy, so it can be used as a retiming or buffering fabric primitive in the logic-cell library.

Parameters:
- WIDTH, 8, data width of each stage (>=1).
- DEPTH, 2, number of register stages (>=1).
- SET_VAL, {WIDTH{1'b1}}, value loaded into every stage by QST.

Ports:
- QCK  input  1  clock; all state updates on its rising edge.
- QRTN  input  1  reset, asynchronous, active-low.
- QST  input  1  synchronous set; loads SET_VAL into all data regs and flushes valids.
- QEN  input  1  clock enable; 0 freezes all state.
- QDS  input  1  input mux select: 1 = QDI, 0 = CZI.
- QDI  input  WIDTH  primary data input.
- CZI  input  WIDTH  alternate data input (from the LUT/logic side).
- QIV  input  1  input valid.
- QIR  output  1  input ready.
- QZ  output  WIDTH  output data (last stage register).
- QZV  output  1  output valid.
- QZR  input  1  output ready from the consumer.

Behaviour:
- Input data: d = QDS ? QDI : CZI, sampled when the input is accepted (QIV & QIR at the QCK edge).
- State per stage i (0 = input side, DEPTH-1 = output side): data[i] (WIDTH bits) and v[i] (1 bit).
- Advance terms, with QEN gating every one of them:
  - adv[DEPTH-1] = QEN & v[DEPTH-1] & QZR.
  - adv[i] = QEN & v[i] & (~v[i+1] | adv[i+1]) for i < DEPTH-1.
- Ready and accept:
  - QIR = QEN & (~v[0] | adv[0]). QIR is combinational through the chain, so a full pipeline accepts in the same cycle it emits.
  - accept = QIV & QIR.
- Per-edge update, evaluated in priority order:
  1. QRTN low (async): all data = 0, all v = 0. This wins over every other input.
  2. QST = 1 (sync): all data = SET_VAL, all v = 0. Acts regardless of QEN; the input is not accepted that cycle.
  3. QEN = 0: hold all state.
  4. Normal operation:
     - Stage i>0 loads data[i-1] and sets v[i] when adv[i-1].
     - Otherwise v[i] clears if adv[i], and holds if not.
     - Stage 0 loads d and sets v[0] on accept; otherwise v[0] clears if adv[0].
     - data[i] holds whenever no load occurs; invalid stages are not forced to 0.
- Outputs: QZ = data[DEPTH-1], QZV = v[DEPTH-1]. After reset QZ = 0, QZV = 0, and QIR = QEN.
- Latency and throughput: DEPTH cycles from accept to QZV with no stall; one word per cycle sustained.
- Ordering: strict FIFO. There is no drop or duplication under any QZR/QEN pattern.
- Full pipeline with QZR = 0: QIR = 0, all data held.
- Bubbles: an empty stage is collapsed by the next advance (bubbles are squeezed out).
- Reset mid-transfer: the in-flight data is lost; QZV drops asynchronously.
- QST and QIV together: QST wins, the word is not accepted, and QIR is still computed normally (the source sees the word as taken). Source integrations must therefore not assert QIV during QST.
- DEPTH = 1: a single register; QIR = QEN & (~v[0] | QZR).
- QZV must not fall without a handshake while QEN = 1 and QST = 0.

Optional Feature:
- Macro: Q_FRAG_PIPE_OCC_EN.
- Defined: adds output port QOCC [$clog2(DEPTH+1)-1:0], the registered count of valid stages.
  - Increments on accept without emit; decrements on emit without accept; unchanged when both or neither occur.
  - Resets to 0 on QRTN and on QST.
  - Never exceeds DEPTH.
- Undefined: no QOCC port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package q_frag_pkg holds:
  - QDS_SEL_QDI = 1'b1, QDS_SEL_CZI = 1'b0.
  - Function occ_w(DEPTH) = $clog2(DEPTH+1).
- Sub-module q_frag_stage: one data register plus valid bit.
  - Inputs: QCK, QRTN, QST, load, clear, d, SET_VAL.
  - Instantiated DEPTH times via generate.
  - adv/ready chain logic stays in the top module.

Test Plan:
- Reset: with QRTN = 0, drive QIV = 1 and data patterns -> QZ = 0, QZV = 0; after QRTN rises with QEN = 1 -> QIR = 1 in the first cycle.
- Streaming (WIDTH = 8, DEPTH = 2, QZR = 1, QDS = 1): send QDI = 0x11, 0x22, 0x33 on consecutive cycles -> QZ shows 0x11, 0x22, 0x33 with QZV = 1 starting 2 cycles after the first accept, one per cycle.
- Backpressure: QZR = 0 with 3 words offered -> 2 accepted, then QIR = 0 and QZ holds the first word. Raise QZR -> QIR = 1 in the same cycle, all words out in order with no loss.
- Mux select: QDS = 0, CZI = 0xA5, QDI = 0x5A -> output word 0xA5. Toggling QDS per word alternates the source correctly.
- QEN / QST: QEN = 0 for 3 cycles mid-stream -> state frozen and QIR = 0. Then QST = 1 for one cycle -> QZ = 0xFF, QZV = 0, and OCC (if enabled) = 0.
- Q_FRAG_PIPE_OCC_EN: random QIV/QZR for 1000 cycles -> QOCC equals the scoreboard count every cycle and stays ≤ DEPTH.
